fetch_unit: RTL and testbench

Instruction fetch stage wrapped around the PC register. It takes the current PC (PC_OUT) and issues a req/ack read to instruction memory. The returned instruction is presented to decode with a valid/ready handshake. It also drives the next PC (PC_IN) back into the PC register: sequential step, hold, or branch redirect. Multicycle fetch: at most one outstanding request.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one req/ack read at a time for the current PC and hands the result to decode with valid/ready.
// Define FETCH_STATS_EN to add a saturating STALL_CNT output.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  PC_OUT,
    output logic [ADDR_W-1:0]  PC_IN,
    output logic               IMEM_REQ,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic               IMEM_ACK,
    input  logic [INSTR_W-1:0] IMEM_DATA,
    output logic [INSTR_W-1:0] INSTR,
    output logic [ADDR_W-1:0]  INSTR_PC,
    output logic               INSTR_VALID,
    input  logic               INSTR_READY,
    input  logic               BR_TAKEN,
    input  logic [ADDR_W-1:0]  BR_TARGET
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        STALL_CNT
`endif
);

    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0] state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_SYNC;
            PC_IN       <= RESET_PC;
            IMEM_REQ    <= 1'b0;
            IMEM_ADDR   <= '0;
            INSTR       <= '0;
            INSTR_PC    <= '0;
            INSTR_VALID <= 1'b0;
        end else if (BR_TAKEN) begin
            // Redirect wins everywhere; an in-flight read cannot be withdrawn, so it is drained.
            PC_IN       <= BR_TARGET;
            INSTR_VALID <= 1'b0;
            case (state_reg)
                S_WAIT, S_DRAIN: begin
                    if (IMEM_ACK) begin
                        IMEM_REQ  <= 1'b0;
                        state_reg <= S_SYNC;
                    end else begin
                        state_reg <= S_DRAIN;
                    end
                end
                default: state_reg <= S_SYNC;
            endcase
        end else begin
            case (state_reg)
                S_SYNC: begin
                    IMEM_REQ  <= 1'b1;
                    IMEM_ADDR <= PC_OUT;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (IMEM_ACK) begin
                        IMEM_REQ    <= 1'b0;
                        INSTR       <= IMEM_DATA;
                        INSTR_PC    <= IMEM_ADDR;
                        INSTR_VALID <= 1'b1;
                        state_reg   <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (INSTR_READY) begin
                        INSTR_VALID <= 1'b0;
                        PC_IN       <= INSTR_PC + PC_STEP;
                        state_reg   <= S_SYNC;
                    end
                end
                S_DRAIN: begin
                    if (IMEM_ACK) begin
                        IMEM_REQ  <= 1'b0;
                        state_reg <= S_SYNC;
                    end
                end
                default: state_reg <= S_SYNC;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic stall;
    assign stall = ((state_reg == S_WAIT) && !IMEM_ACK) || (INSTR_VALID && !INSTR_READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            STALL_CNT <= '0;
        end else if (stall && (STALL_CNT != 32'hFFFF_FFFF)) begin
            STALL_CNT <= STALL_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vector table, directed corner sequences,
// then randomized traffic checked against a transaction-level model of the PC stream.
module tb_fetch_unit;

    localparam logic [31:0] IBASE = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PC_OUT = '0;
    logic [31:0] PC_IN;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_DATA = '0;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic [31:0] BR_TARGET = '0;
`ifdef FETCH_STATS_EN
    logic [31:0] STALL_CNT;
`endif

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .PC_OUT(PC_OUT), .PC_IN(PC_IN),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
        .INSTR(INSTR), .INSTR_PC(INSTR_PC), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET)
`ifdef FETCH_STATS_EN
        , .STALL_CNT(STALL_CNT)
`endif
    );

    always #5 clk = ~clk;

    // PC register model: captures PC_IN on the falling edge.
    always @(negedge clk) PC_OUT = PC_IN;

    int n_checks = 0;
    int n_fail = 0;

    logic        pre_valid, pre_ready, pre_br, pre_req;
    logic [31:0] pre_tgt, pre_addr, pre_pc_in;

    typedef struct {
        logic        ack;
        logic [31:0] data;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic [31:0] pc_in;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(logic ack, logic [31:0] data, logic rdy, logic req, logic [31:0] addr,
                                logic vld, logic [31:0] ipc, logic [31:0] instr, logic [31:0] pc_in);
        vec_t v;
        v.ack = ack; v.data = data; v.rdy = rdy; v.req = req; v.addr = addr;
        v.vld = vld; v.ipc = ipc; v.instr = instr; v.pc_in = pc_in;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic ack, input logic [31:0] data, input logic rdy,
                          input logic br, input logic [31:0] tgt);
        IMEM_ACK = ack; IMEM_DATA = data; INSTR_READY = rdy; BR_TAKEN = br; BR_TARGET = tgt;
    endtask

    task automatic step();
        pre_valid = INSTR_VALID; pre_ready = INSTR_READY; pre_br = BR_TAKEN; pre_tgt = BR_TARGET;
        pre_req = IMEM_REQ; pre_addr = IMEM_ADDR; pre_pc_in = PC_IN;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] exp_pc;
    int          xfers;
    int          delay;
    logic        req_seen;

    initial begin
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a, hold_pc, hold_in;
            a = 32'(k);
            hold_pc = (k == 0) ? 32'd0 : a - 32'd1;
            hold_in = (k == 0) ? 32'd0 : IBASE + a - 32'd1;
            vecs[3*k]   = mk(1'b0, '0,       1'b1, 1'b1, a, 1'b0, hold_pc, hold_in,  a);
            vecs[3*k+1] = mk(1'b1, IBASE + a, 1'b1, 1'b0, a, 1'b1, a,       IBASE + a, a);
            vecs[3*k+2] = mk(1'b0, '0,       1'b1, 1'b0, a, 1'b0, a,       IBASE + a, a + 32'd1);
        end

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc_in", PC_IN, 32'd0);
        check("rst_req", 32'(IMEM_REQ), 32'd0);
        check("rst_addr", IMEM_ADDR, 32'd0);
        check("rst_instr", INSTR, 32'd0);
        check("rst_instr_pc", INSTR_PC, 32'd0);
        check("rst_valid", 32'(INSTR_VALID), 32'd0);
        rst_n = 1'b1;

        // Back-to-back fetches: one transfer every 3 cycles
        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].ack, vecs[i].data, vecs[i].rdy, 1'b0, '0);
            step();
            $display("vec %0d: req=%0b addr=%h valid=%0b instr_pc=%h instr=%h pc_in=%h",
                     i, IMEM_REQ, IMEM_ADDR, INSTR_VALID, INSTR_PC, INSTR, PC_IN);
            check("vec_req", 32'(IMEM_REQ), 32'(vecs[i].req));
            check("vec_addr", IMEM_ADDR, vecs[i].addr);
            check("vec_valid", 32'(INSTR_VALID), 32'(vecs[i].vld));
            check("vec_instr_pc", INSTR_PC, vecs[i].ipc);
            check("vec_instr", INSTR, vecs[i].instr);
            check("vec_pc_in", PC_IN, vecs[i].pc_in);
        end

        // Slow memory at address 4
        set_in(1'b0, '0, 1'b1, 1'b1, 32'd4); step();
        check("slow_br_pc_in", PC_IN, 32'd4);
        set_in(1'b0, '0, 1'b1, 1'b0, '0); step();
        check("slow_req_rise", 32'(IMEM_REQ), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("slow_req_hold", 32'(IMEM_REQ), 32'd1);
            check("slow_addr_hold", IMEM_ADDR, 32'd4);
            check("slow_valid_low", 32'(INSTR_VALID), 32'd0);
        end
        set_in(1'b1, IBASE + 32'd4, 1'b1, 1'b0, '0); step();
        check("slow_valid", 32'(INSTR_VALID), 32'd1);
        check("slow_instr_pc", INSTR_PC, 32'd4);
        set_in(1'b0, '0, 1'b1, 1'b0, '0); step();
        check("slow_pc_in", PC_IN, 32'd5);
        $display("seq slow-ack done");

        // Decode back-pressure at PC 7
        set_in(1'b0, '0, 1'b0, 1'b1, 32'd7); step();
        set_in(1'b0, '0, 1'b0, 1'b0, '0); step();
        check("bp_addr", IMEM_ADDR, 32'd7);
        set_in(1'b1, IBASE + 32'd7, 1'b0, 1'b0, '0); step();
        set_in(1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_valid", 32'(INSTR_VALID), 32'd1);
            check("bp_instr_pc", INSTR_PC, 32'd7);
            check("bp_instr", INSTR, IBASE + 32'd7);
            check("bp_pc_in", PC_IN, 32'd7);
        end
        INSTR_READY = 1'b1; step();
        check("bp_release_pc_in", PC_IN, 32'd8);
        check("bp_release_valid", 32'(INSTR_VALID), 32'd0);
        $display("seq back-pressure done");

        // Redirect while a read is outstanding
        set_in(1'b0, '0, 1'b1, 1'b0, '0); step();
        check("drain_req_addr", IMEM_ADDR, 32'd8);
        set_in(1'b0, '0, 1'b1, 1'b1, 32'h40); step();
        check("drain_pc_in", PC_IN, 32'h40);
        check("drain_req_held", 32'(IMEM_REQ), 32'd1);
        set_in(1'b0, '0, 1'b1, 1'b0, '0); step();
        check("drain_valid0", 32'(INSTR_VALID), 32'd0);
        set_in(1'b1, 32'hDEAD, 1'b1, 1'b0, '0); step();
        check("drain_valid1", 32'(INSTR_VALID), 32'd0);
        check("drain_req_drop", 32'(IMEM_REQ), 32'd0);
        set_in(1'b0, '0, 1'b1, 1'b0, '0); step();
        check("drain_valid2", 32'(INSTR_VALID), 32'd0);
        check("drain_new_addr", IMEM_ADDR, 32'h40);
        check("drain_new_req", 32'(IMEM_REQ), 32'd1);
        set_in(1'b1, IBASE + 32'h40, 1'b1, 1'b0, '0); step();
        check("drain_instr", INSTR, IBASE + 32'h40);
        check("drain_instr_pc", INSTR_PC, 32'h40);
        set_in(1'b0, '0, 1'b1, 1'b0, '0); step();
        check("drain_next_pc", PC_IN, 32'h41);
        $display("seq redirect-drain done");

        // PC wrap
        set_in(1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FFFF); step();
        set_in(1'b0, '0, 1'b1, 1'b0, '0); step();
        check("wrap_addr", IMEM_ADDR, 32'hFFFF_FFFF);
        set_in(1'b1, IBASE + 32'hFFFF_FFFF, 1'b1, 1'b0, '0); step();
        check("wrap_instr_pc", INSTR_PC, 32'hFFFF_FFFF);
        set_in(1'b0, '0, 1'b1, 1'b0, '0); step();
        check("wrap_pc_in", PC_IN, 32'd0);
        $display("seq wrap done");

        // Asynchronous reset during an outstanding request, then a stale ack
        step();
        step();
        check("arst_pre_req", 32'(IMEM_REQ), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_req", 32'(IMEM_REQ), 32'd0);
        check("arst_valid", 32'(INSTR_VALID), 32'd0);
        check("arst_pc_in", PC_IN, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(1'b1, 32'h0BAD, 1'b1, 1'b0, '0); step();
        check("stale_valid", 32'(INSTR_VALID), 32'd0);
        check("stale_req", 32'(IMEM_REQ), 32'd1);
        set_in(1'b0, '0, 1'b1, 1'b0, '0); step();
        check("stale_valid2", 32'(INSTR_VALID), 32'd0);
        set_in(1'b1, IBASE, 1'b1, 1'b0, '0); step();
        check("stale_instr", INSTR, IBASE);
        check("stale_instr_pc", INSTR_PC, 32'd0);
        set_in(1'b0, '0, 1'b1, 1'b0, '0); step();
        check("stale_pc_in", PC_IN, 32'd1);
        $display("seq async-reset done");

        // Randomized traffic against the PC-stream model
        do_reset();
        exp_pc = 32'd0;
        xfers = 0;
        delay = 0;
        req_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            INSTR_READY = ($urandom_range(0, 3) != 0);
            BR_TAKEN = ($urandom_range(0, 11) == 0);
            BR_TARGET = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1)) : $urandom;
            if (IMEM_ACK) begin
                IMEM_ACK = 1'b0;
            end else if (IMEM_REQ) begin
                if (!req_seen) begin
                    delay = $urandom_range(0, 3);
                    req_seen = 1'b1;
                end
                if (delay == 0) begin
                    IMEM_ACK = 1'b1;
                    IMEM_DATA = IBASE + IMEM_ADDR;
                    req_seen = 1'b0;
                end else begin
                    delay--;
                end
            end
            step();
            if (pre_valid && pre_ready) begin
                xfers++;
                $display("xfer %0d: instr_pc=%h instr=%h expected_pc=%h", xfers, INSTR_PC, INSTR, exp_pc);
                check("rnd_instr_pc", INSTR_PC, exp_pc);
                check("rnd_instr", INSTR, IBASE + exp_pc);
                exp_pc = exp_pc + 32'd1;
            end
            if (pre_br) exp_pc = pre_tgt;
            check("rnd_pc_in", PC_IN, exp_pc);
            if (IMEM_REQ && !pre_req) check("rnd_fetch_addr", IMEM_ADDR, pre_pc_in);
            if (IMEM_REQ && pre_req) check("rnd_addr_stable", IMEM_ADDR, pre_addr);
        end
        check("rnd_progress", 32'(xfers > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
